// File: rtl/hazard_tracker_pkg.sv
// hazard_tracker_pkg: shared widths, zero register and stage record for the hazard tracker
package hazard_tracker_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic regwrite;
    logic memread;
    logic [DATA_W-1:0] data;
  } stage_t;
endpackage

// File: rtl/hazard_tracker_stage_reg.sv
// stage_reg: pipeline stage record register with synchronous clear and bubble insertion
module stage_reg
  import hazard_tracker_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);
  always_ff @(posedge clk)
    q <= (reset || bubble) ? '0 : d;
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: EX/MEM and MEM/WB stage tracking, forwarding sources, write-back port and load-use stall
module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              stall,
  output logic [REG_W-1:0]  rd_m1,
  output logic [REG_W-1:0]  rd_m2,
  output logic [DATA_W-1:0] fwd_m1_data,
  output logic [DATA_W-1:0] fwd_m2_data,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data
);
  stage_t m1_d, m1_q, m2_d, m2_q;
  assign m1_d = '{rd: ex_rd, regwrite: ex_regwrite, memread: ex_memread, data: ex_result};
  // a load's value only exists once memory returns it, so it is substituted on the way into M2
  assign m2_d = '{rd: m1_q.rd, regwrite: m1_q.regwrite, memread: m1_q.memread,
                  data: m1_q.memread ? mem_rdata : m1_q.data};
  stage_reg u_m1 (.clk(clk), .reset(reset), .bubble(flush), .d(m1_d), .q(m1_q));
  stage_reg u_m2 (.clk(clk), .reset(reset), .bubble(1'b0), .d(m2_d), .q(m2_q));
  // a squashed load never reaches memory, so it cannot create a hazard
  assign stall = !reset && !flush && ex_memread && ex_regwrite && ex_rd != ZERO_REG &&
                 (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  assign rd_m1 = m1_q.regwrite ? m1_q.rd : ZERO_REG;
  assign rd_m2 = m2_q.regwrite ? m2_q.rd : ZERO_REG;
  assign fwd_m1_data = m1_q.data;
  assign fwd_m2_data = m2_q.data;
  assign wb_we = m2_q.regwrite && m2_q.rd != ZERO_REG;
  assign wb_rd = m2_q.rd;
  assign wb_data = m2_q.data;
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: scoreboard bench for hazard_tracker against an independent stage model
module tb_hazard_tracker;
  import hazard_tracker_pkg::*;
  typedef struct packed {
    stage_t m1;
    stage_t m2;
  } snap_t;
  logic clk = 0, reset = 0;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rd = 0;
  logic id_uses_rt = 0, ex_regwrite = 0, ex_memread = 0, flush = 0;
  logic [31:0] ex_result = 0, mem_rdata = 0;
  logic stall, wb_we;
  logic [4:0] rd_m1, rd_m2, wb_rd;
  logic [31:0] fwd_m1_data, fwd_m2_data, wb_data;
  int checks = 0, failures = 0;
  stage_t m1 = '0, m2 = '0;
  snap_t sb[$];
  hazard_tracker dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_result(ex_result),
    .mem_rdata(mem_rdata), .flush(flush), .stall(stall), .rd_m1(rd_m1), .rd_m2(rd_m2),
    .fwd_m1_data(fwd_m1_data), .fwd_m2_data(fwd_m2_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic [4:0] erd, input logic rw, input logic mr,
                     input logic [31:0] res, input logic [31:0] mrd, input logic fl);
    stage_t n1, n2;
    snap_t s;
    logic es;
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = erd;
    ex_regwrite = rw; ex_memread = mr; ex_result = res; mem_rdata = mrd; flush = fl;
    #2;
    es = !r && !fl && mr && rw && erd != 0 && (erd == rs || (urt && erd == rt));
    check("stall", {31'b0, stall}, {31'b0, es});
    n2 = m1;
    if (m1.memread) n2.data = mrd;
    n1 = fl ? '0 : '{rd: erd, regwrite: rw, memread: mr, data: res};
    if (r) begin
      n1 = '0;
      n2 = '0;
    end
    sb.push_back('{m1: n1, m2: n2});
    @(posedge clk);
    #1;
    s = sb.pop_front();
    m1 = s.m1;
    m2 = s.m2;
    check("rd_m1", {27'b0, rd_m1}, {27'b0, m1.regwrite ? m1.rd : 5'd0});
    check("rd_m2", {27'b0, rd_m2}, {27'b0, m2.regwrite ? m2.rd : 5'd0});
    check("fwd_m1_data", fwd_m1_data, m1.data);
    check("fwd_m2_data", fwd_m2_data, m2.data);
    check("wb_we", {31'b0, wb_we}, {31'b0, m2.regwrite && m2.rd != 0});
    check("wb_rd", {27'b0, wb_rd}, {27'b0, m2.rd});
    check("wb_data", wb_data, m2.data);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge clk);
    #1;
    cyc(1, 9, 0, 0, 9, 1, 1, 32'h55, 32'h66, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    check("rst_rd_m1", {27'b0, rd_m1}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    cyc(0, 1, 2, 1, 8, 1, 0, 32'h1234, 32'h0, 0);
    check("alu_rd_m1", {27'b0, rd_m1}, 32'd8);
    check("alu_fwd_m1", fwd_m1_data, 32'h1234);
    idle();
    check("alu_rd_m2", {27'b0, rd_m2}, 32'd8);
    check("alu_wb_we", {31'b0, wb_we}, 32'd1);
    check("alu_wb_data", wb_data, 32'h1234);
    cyc(0, 9, 3, 0, 9, 1, 1, 32'h100, 32'h0, 0);
    check("ld_rd_m1", {27'b0, rd_m1}, 32'd9);
    cyc(0, 9, 3, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 0);
    check("ld_rd_m2", {27'b0, rd_m2}, 32'd9);
    check("ld_fwd_m2", fwd_m2_data, 32'hDEADBEEF);
    idle();
    cyc(0, 1, 9, 1, 9, 1, 1, 32'h200, 32'h0, 0);
    cyc(0, 1, 9, 0, 9, 1, 1, 32'h300, 32'hCAFE0001, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h400, 32'hCAFE0002, 0);
    check("zero_rd_m1", {27'b0, rd_m1}, 32'd0);
    idle();
    idle();
    check("zero_wb_we", {31'b0, wb_we}, 32'd0);
    cyc(0, 5, 0, 0, 5, 1, 1, 32'h500, 32'h0, 1);
    check("flush_rd_m1", {27'b0, rd_m1}, 32'd0);
    check("flush_m1_data", fwd_m1_data, 32'd0);
    cyc(0, 0, 0, 0, 7, 1, 0, 32'h71, 32'h0, 0);
    cyc(0, 0, 0, 0, 7, 1, 0, 32'h72, 32'h0, 0);
    check("dup_rd_m1", {27'b0, rd_m1}, 32'd7);
    check("dup_rd_m2", {27'b0, rd_m2}, 32'd7);
    cyc(0, 0, 0, 0, 3, 1, 0, 32'h33, 32'h0, 0);
    cyc(0, 0, 0, 0, 4, 1, 1, 32'h44, 32'h0, 0);
    cyc(1, 4, 4, 1, 6, 1, 1, 32'h66, 32'h77, 1);
    check("mid_rst_rd_m2", {27'b0, rd_m2}, 32'd0);
    check("mid_rst_wb_we", {31'b0, wb_we}, 32'd0);
    for (int i = 0; i < 40; i++)
      cyc(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
          5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, $urandom,
          $urandom_range(0, 7) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports `clk` and `reset` SHALL be listed first.
REQ-002 `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 `id_rs` and `id_rt`, input, 5 bits each: source register addresses of the instruction in ID.
REQ-005 `id_uses_rt`, input, 1 bit: the ID instruction reads RT (R-type, SW, branch, output).
REQ-006 `ex_rd`, input, 5 bits: destination address of the EX instruction, taken after the RegDst mux.
REQ-007 `ex_regwrite` and `ex_memread`, input, 1 bit each: the EX instruction writes a register / is a load.
REQ-008 `ex_result`, input, 32 bits: ALU result of the EX instruction.
REQ-009 `mem_rdata`, input, 32 bits: data-memory read data for the M1 instruction.
REQ-010 `flush`, input, 1 bit: taken-branch squash of the EX instruction.
REQ-011 `stall`, output, 1 bit: load-use hazard; upstream holds PC and IF/ID and injects a bubble into ID/EX.
REQ-012 `rd_m1` and `rd_m2`, output, 5 bits each: destinations of inst-1 and inst-2; these feed the forwarding unit's RD_M1 and RD_M2.
REQ-013 `fwd_m1_data` and `fwd_m2_data`, output, 32 bits each: forwardable results for inst-1 and inst-2.
REQ-014 `wb_we` (1 bit), `wb_rd` (5 bits) and `wb_data` (32 bits), outputs: register-file write port.

Function
REQ-015 The block SHALL hold two stage registers, M1 (EX/MEM) and M2 (MEM/WB). Each holds rd[4:0], regwrite, memread and data[31:0].
REQ-016 Each cycle, M2 SHALL capture M1.
- data SHALL be mem_rdata when M1.memread=1.
- Otherwise data SHALL be M1.data.
REQ-017 Each cycle, M1 SHALL capture {ex_rd, ex_regwrite, ex_memread, ex_result}, except in the case of REQ-018.
REQ-018 When flush=1, M1 SHALL instead capture a bubble (all fields zero).
REQ-019 rd_m1 SHALL equal M1.rd when M1.regwrite=1, else 5'h0. rd_m2 SHALL follow the same rule from M2. Zero means no forward.
REQ-020 fwd_m1_data SHALL equal M1.data, and fwd_m2_data SHALL equal M2.data.
REQ-021 wb_we SHALL equal M2.regwrite AND (M2.rd != 0); wb_rd = M2.rd; wb_data = M2.data.
REQ-022 stall SHALL be combinational and SHALL be 1 only when all of the following hold:
- ex_memread=1
- ex_regwrite=1
- ex_rd != 0
- ex_rd == id_rs, or (id_uses_rt=1 and ex_rd == id_rt)
REQ-023 A load-use hazard SHALL cost exactly one stall cycle. The next cycle's EX holds the bubble, and the load sits in M1.
REQ-024 While a load is in M1, it SHALL appear in rd_m1 but SHALL NOT be forwardable from M1. Its value SHALL be forwarded from M2 one cycle later.
REQ-025 When flush=1 and the stall condition hold in the same cycle, flush SHALL win and stall SHALL be 0.
REQ-026 A write to $0 SHALL never stall, never forward and never write back.
REQ-027 When M1 and M2 hold the same rd, both SHALL be reported. Priority is the forwarding unit's job (inst-1 wins).
REQ-028 Latency SHALL be as follows:
- EX inputs are visible on rd_m1 and fwd_m1_data one cycle later.
- They are visible on rd_m2 and wb_* two cycles later.

Reset
REQ-029 When reset=1 at a clock edge, M1 and M2 SHALL clear to all zero.
REQ-030 After reset, all outputs SHALL be 0: stall, rd_m1, rd_m2, fwd_m1_data, fwd_m2_data, wb_we, wb_rd, wb_data.
REQ-031 Reset SHALL take precedence over flush and over normal capture, including when asserted mid-operation.
REQ-032 stall SHALL be forced to 0 while reset=1.

Structure
REQ-033 A shared package SHALL hold:
- the 5-bit register-address and 32-bit data-width constants
- the zero-register constant
- the stage-record typedef {rd, regwrite, memread, data}
REQ-034 A single sub-module `stage_reg` SHALL be instantiated twice. It is a stage record register with synchronous clear and a bubble input.

Verification
REQ-035 ALU write, no hazard: ex_rd=8, ex_regwrite=1, ex_result=32'h1234. The bench SHALL see:
- next cycle: rd_m1=8, fwd_m1_data=32'h1234
- following cycle: rd_m2=8, wb_we=1, wb_rd=8, wb_data=32'h1234
REQ-036 Load-use on RS: EX is a load to $9, id_rs=9. The bench SHALL see:
- stall=1 for one cycle
- after a bubble, rd_m2=9 with fwd_m2_data = mem_rdata captured (e.g., 32'hDEADBEEF)
REQ-037 Load-use on RT:
- EX load to $9, id_rt=9, id_uses_rt=1 -> stall=1
- the same with id_uses_rt=0 -> stall=0
REQ-038 Write to $0: ex_rd=0, ex_regwrite=1, ex_memread=1, id_rs=0 -> stall=0, rd_m1=0, and wb_we=0 two cycles later.
REQ-039 Flush during stall: load to $5 in EX, id_rs=5, flush=1 -> stall=0, and the next cycle has rd_m1=0 and M1 all zero.
REQ-040 Reset mid-stream: M1 and M2 loaded (rd 3 and 4), then reset=1 for one cycle -> all outputs 0 on the next cycle.
